// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and constants for the TDM demultiplexer.
//   state_t      - receiver framing state (HUNT / RUN)
//   DEF_CHANNELS - default slots per frame
//   DEF_WIDTH    - default bits per channel sample
//   ERRCNT_MAX   - saturation value of the framing-error counter
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CHANNELS = 8;
  localparam int DEF_WIDTH    = 1;

  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-CHANNELS slot index with synchronous load-to-1.
//   clk, rst_n - clock, async active-low reset
//   adv        - advance to the next slot (wraps to 0 after CHANNELS-1)
//   load1      - restart a frame: the current sample took slot 0, next is 1
//   slot       - index the next accepted sample will occupy
//   wrap       - advancing out of the last slot this cycle
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             load1,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);

  assign wrap = adv && (slot == SEL_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SEL_W'(1);
    end else if (adv) begin
      slot <= wrap ? '0 : slot + SEL_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the TDM path. Steers one serial sample per slot
// into a shadow frame and publishes the whole frame at once when the last
// slot is filled.
//   clk, rst_n  - clock, async active-low reset
//   in_valid    - sample present on in_data
//   in_data     - serial sample
//   frame_start - with in_valid, marks the sample as slot 0
//   out         - last complete frame, slot k at [k*WIDTH +: WIDTH]
//   out_valid   - one-cycle pulse when out updates
//   slot        - index the next accepted sample will occupy
//   synced      - high while in RUN
//   frame_err   - one-cycle pulse on frame_start at a non-zero slot
//   err_count   - saturating framing-error count; only built when
//                 TDM_DEMUX_ERRCNT_EN is defined, otherwise tied to 0
//
// state | meaning
// HUNT  | waiting for the first frame_start, samples discarded
// RUN   | locked, every valid sample fills the next slot
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      frame_start,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          slot,
  output logic                      synced,
  output logic                      frame_err,
  output logic [7:0]                err_count
);

  state_t                    state;
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic [CHANNELS*WIDTH-1:0] shadow_nxt;
  logic [SEL_W-1:0]          wr_idx;
  logic                      hunt_start;
  logic                      viol;
  logic                      restart;
  logic                      adv;
  logic                      wrap;

  assign hunt_start = (state == HUNT) && in_valid && frame_start;
  assign viol       = (state == RUN) && in_valid && frame_start && (slot != '0);
  // Both a first lock and a framing violation make the current sample slot 0.
  assign restart    = hunt_start || viol;
  assign adv        = (state == RUN) && in_valid && !viol;
  assign synced     = (state == RUN);

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .load1 (restart),
    .slot  (slot),
    .wrap  (wrap)
  );

  // Shadow with the current sample merged in, so the last slot can be
  // published on the same edge that accepts it.
  always_comb begin
    wr_idx     = restart ? '0 : slot;
    shadow_nxt = shadow;
    if (restart || adv) begin
      shadow_nxt[int'(wr_idx)*WIDTH +: WIDTH] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= wrap;
      frame_err <= viol;
      shadow    <= shadow_nxt;
      if (wrap) begin
        out <= shadow_nxt;
      end
      if (hunt_start) begin
        state <= RUN;
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (viol && (err_cnt_q != ERRCNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int W  = 1;
  localparam int CH = 8;
  localparam int SW = $clog2(CH);
`ifdef TDM_DEMUX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            frame_start = 1'b0;
  logic [CH*W-1:0] out;
  logic            out_valid;
  logic [SW-1:0]   slot;
  logic            synced;
  logic            frame_err;
  logic [7:0]      err_count;

  tdm_demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .frame_start (frame_start),
    .out         (out),
    .out_valid   (out_valid),
    .slot        (slot),
    .synced      (synced),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulse_t[$];

  // Reference model: a frame is the list of samples collected since the
  // last frame boundary.
  logic            q[$];
  bit              m_sync;
  logic [CH*W-1:0] m_out;
  bit              m_valid;
  bit              m_err;
  int              m_errs;

  function automatic void model_reset();
    q.delete();
    m_sync = 0; m_out = '0; m_valid = 0; m_err = 0; m_errs = 0;
  endfunction

  function automatic void model_step(input bit v, input bit fs, input logic d);
    m_valid = 0;
    m_err   = 0;
    if (!v) return;
    if (!m_sync) begin
      if (fs) begin
        m_sync = 1;
        q = '{d};
      end
    end else if (fs && q.size() != 0) begin
      m_err = 1;
      if (m_errs < 255) m_errs++;
      q = '{d};
    end else begin
      q.push_back(d);
    end
    if (q.size() == CH) begin
      for (int i = 0; i < CH; i++) m_out[i] = q[i];
      m_valid = 1;
      q.delete();
    end
  endfunction

  task automatic check(input string tag);
    logic [SW-1:0] e_slot;
    logic [7:0]    e_cnt;
    e_slot = SW'(q.size());
    e_cnt  = ERRCNT_ON ? 8'(m_errs) : 8'd0;
    checks++;
    assert (out === m_out) else begin
      errors++; $error("FAIL %s out: got %h want %h", tag, out, m_out);
    end
    checks++;
    assert (out_valid === m_valid) else begin
      errors++; $error("FAIL %s out_valid: got %b want %b", tag, out_valid, m_valid);
    end
    checks++;
    assert (slot === e_slot) else begin
      errors++; $error("FAIL %s slot: got %0d want %0d", tag, slot, e_slot);
    end
    checks++;
    assert (synced === m_sync) else begin
      errors++; $error("FAIL %s synced: got %b want %b", tag, synced, m_sync);
    end
    checks++;
    assert (frame_err === m_err) else begin
      errors++; $error("FAIL %s frame_err: got %b want %b", tag, frame_err, m_err);
    end
    checks++;
    assert (err_count === e_cnt) else begin
      errors++; $error("FAIL %s err_count: got %0d want %0d", tag, err_count, e_cnt);
    end
  endtask

  task automatic step(input bit v, input bit fs, input logic d, input string tag);
    in_valid    = v;
    frame_start = fs;
    in_data     = d;
    @(posedge clk);
    model_step(v, fs, d);
    cyc++;
    #1;
    if (out_valid === 1'b1) pulse_t.push_back(cyc);
    check(tag);
  endtask

  task automatic send_frame(input logic [7:0] f, input bit fs0, input string tag);
    for (int i = 0; i < CH; i++) step(1, fs0 && i == 0, f[i], tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_eq(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [7:0] frame_a;
    int         t0;
    model_reset();
    #12;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Samples before any frame_start are discarded.
    for (int i = 0; i < 3; i++) step(1, 0, 1'b1, "hunt_discard");
    step(0, 1, 1'b1, "fs_no_valid_hunt");

    // First frame, known pattern.
    frame_a = 8'b01001101;
    send_frame(frame_a, 1, "frame1");
    expect_eq("frame1_value", int'(out), int'(frame_a));
    step(0, 0, 1'b0, "idle");

    // Back-to-back: random frame then A5 without frame_start.
    pulse_t.delete();
    send_frame(8'($urandom), 1, "b2b_first");
    send_frame(8'hA5, 0, "b2b_a5");
    expect_eq("b2b_pulses", pulse_t.size(), 2);
    if (pulse_t.size() == 2) expect_eq("b2b_spacing", pulse_t[1] - pulse_t[0], CH);
    expect_eq("b2b_value", int'(out), 8'hA5);

    // Framing violation at slot 5, then recovery.
    for (int i = 0; i < 5; i++) step(1, i == 0, 1'($urandom), "pre_err");
    step(1, 1, 1'b1, "viol_slot5");
    expect_eq("viol_out_hold", int'(out), 8'hA5);
    for (int i = 1; i < CH; i++) step(1, 0, 1'($urandom), "post_err");
    send_frame(8'h96, 0, "recover");
    expect_eq("recover_value", int'(out), 8'h96);

    // Gapped frame: 1..3 idle cycles between samples, stray frame_start while idle.
    pulse_t.delete();
    t0 = cyc;
    for (int i = 0; i < CH; i++) begin
      step(1, i == 0, frame_a[i], "gap_sample");
      if (i != CH - 1)
        repeat ($urandom_range(1, 3)) step(0, 1'($urandom), 1'($urandom), "gap_idle");
    end
    expect_eq("gap_value", int'(out), int'(frame_a));
    expect_eq("gap_pulses", pulse_t.size(), 1);
    if (pulse_t.size() == 1) expect_eq("gap_delayed", int'(pulse_t[0] - t0 > CH), 1);

    // Reset mid-frame after slot 4.
    for (int i = 0; i < 4; i++) step(1, i == 0, 1'b1, "pre_rst");
    async_reset("async_reset");
    for (int i = 0; i < 4; i++) step(1, 0, 1'b1, "after_rst_hunt");
    step(1, 1, 1'b0, "relock");
    for (int i = 0; i < 300; i++) step(1, 1, 1'($urandom), "forced_err");
    expect_eq("err_saturate", int'(err_count), ERRCNT_ON ? 255 : 0);
    async_reset("reset2");

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0, 1'($urandom), "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the 8-channel mux path. It takes one serialized sample stream, one sample per slot, and a frame marker. It steers each sample into its channel slot and presents a complete, coherent parallel frame on the outputs once all slots are filled. It sits between the serial link (or the mux-driven test path on the board) and the parallel channel consumers: LEDs and downstream logic.

## Interface
Parameters:
- WIDTH, 1, bits per channel sample
- CHANNELS, 8, slots per frame (≥2)
- SEL_W, $clog2(CHANNELS), slot index width (derived, not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present on in_data this cycle
- in_data  in  WIDTH  serial sample
- frame_start  in  1  qualifies in_valid; marks the current sample as slot 0
- out  out  CHANNELS*WIDTH  last complete frame; slot k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse when out updates
- slot  out  SEL_W  index the next accepted sample will occupy
- synced  out  1  high while in RUN
- frame_err  out  1  one-cycle pulse on a framing violation
- err_count  out  8  saturating framing-error count (see Configuration)

## Operation
- Two states: HUNT and RUN. Reset enters HUNT.
- HUNT:
  - in_valid without frame_start is discarded.
  - in_valid with frame_start stores the sample in shadow slot 0, sets slot=1 and moves to RUN.
- RUN, on in_valid:
  - The sample is written to shadow[slot] and slot increments.
  - At slot==CHANNELS-1 the slot counter wraps to 0. On that same edge, the shadow contents plus the current sample load into out.
  - frame_start is optional at slot 0. If present, it is accepted silently.
- Framing violation: frame_start with in_valid while slot≠0 in RUN.
  - frame_err pulses and the partial frame is discarded; out is unchanged.
  - The current sample becomes slot 0, slot=1, and the block stays in RUN.
- No in_valid: state, slot and shadow hold. There is no timeout.
- frame_start without in_valid is ignored in every state.
- The shadow register is not cleared between frames. Slots are always fully overwritten before any transfer.

## Timing
- Reset values: out=0, out_valid=0, slot=0, synced=0, frame_err=0, err_count=0, shadow=0.
- out and out_valid change on the clock edge that accepts slot CHANNELS-1, so they are visible the following cycle. Latency from the last sample is 1 cycle.
- Back-to-back in_valid is supported at full rate, one sample per clock. Consecutive frames give out_valid every CHANNELS cycles.
- synced rises the cycle after the first accepted frame_start.
- frame_err is visible the cycle after the offending edge.
- Reset asserted mid-frame clears everything immediately, including the shadow. The partial frame is lost and out_valid does not pulse.

## Configuration
- Macro TDM_DEMUX_ERRCNT_EN.
- Defined: err_count increments on each frame_err and saturates at 255. It clears only on reset.
- Undefined: the counter logic is not built and err_count is tied to 0. The port exists either way.

## Structure
- Package tdm_demux_pkg holds:
  - the state encoding (HUNT=1'b0, RUN=1'b1),
  - the default CHANNELS/WIDTH constants,
  - the ERRCNT_MAX=8'hFF constant.
- Sub-module tdm_slot_counter: modulo-CHANNELS counter with synchronous load-to-1 and a wrap flag. The top holds the FSM, the shadow and out registers, and error handling.

## Test plan
Defaults WIDTH=1, CHANNELS=8.
- Reset, then 8 valid samples 1,0,1,1,0,0,1,0 with frame_start on the first -> out=8'b01001101 one cycle after the 8th, out_valid single pulse, synced=1.
- After reset, 3 samples with no frame_start -> out=0, no out_valid, synced=0, slot=0.
- Two back-to-back frames, second = 8'hA5 bit-serial LSB first, frame_start only on the first -> out_valid pulses exactly 8 cycles apart, out=8'hA5 after the second.
- frame_start at slot 5 mid-frame -> frame_err pulse, err_count=1 (macro defined), out unchanged. The following 8 samples produce a correct frame.
- in_valid gaps of 1–3 idle cycles within a frame -> the same out value as the gapless case, with out_valid delayed accordingly.
- rst_n low after slot 4 of a frame -> all outputs 0 asynchronously. The next frame requires frame_start, and 300 forced errors give err_count=255 (saturation).
